// File: rtl/imem_boot_loader.sv
// Boot loader: unpacks a framed byte stream (MAGIC, LEN, words, XOR checksum) into IMEM and
// holds the core in reset until a good frame lands. Optional inter-byte timeout: BOOT_TIMEOUT_EN.
module imem_boot_loader #(
  parameter int          IMEM_DEPTH_WORDS = 4096,
  parameter logic [7:0]  MAGIC_BYTE       = 8'hA5,
  parameter int          TIMEOUT_CYCLES   = 65535,
  localparam int         AW               = $clog2(IMEM_DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [2:0]    dbg_state
);

  // Handshake: a byte transfers on a rising edge when in_valid && in_ready; in_ready depends
  // only on the registered state (low in RUN only) and never on in_valid.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(IMEM_DEPTH_WORDS);

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   asm_q, asm_d;
  logic [7:0]    csum_q, csum_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          accept;
  logic [15:0]   len_full;

`ifdef BOOT_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] to_cnt_q, to_cnt_d;
`endif

  assign in_ready   = (state_q != S_RUN);
  assign accept     = in_valid && in_ready;
  assign len_full   = {in_data, len_q[7:0]};
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign busy       = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
  assign done       = (state_q == S_RUN);
  assign error      = (state_q == S_ERR);
  assign dbg_state  = state_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    csum_d      = csum_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    // Core release lags entry into RUN by one edge.
    cpu_rst_n_d = (state_q == S_RUN);

    case (state_q)
      S_IDLE, S_ERR: begin
        if (accept && in_data == MAGIC_BYTE) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d[15:8] = in_data;
          word_cnt_d  = '0;
          byte_idx_d  = '0;
          csum_d      = '0;
          if ({1'b0, len_full} > DEPTH_W) state_d = S_ERR;
          else if (len_full == 16'd0)     state_d = S_CSUM;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          asm_d      = {in_data, asm_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            waddr_d    = word_cnt_q[AW-1:0];
            wdata_d    = {in_data, asm_q};
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == len_q) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? S_RUN : S_ERR;
      end
      default: ;
    endcase
  end

`ifdef BOOT_TIMEOUT_EN
  // Idle counter only runs mid-frame; an accepted byte always wins over a timeout.
  always_comb begin
    to_cnt_d = '0;
    if (busy && !accept) to_cnt_d = to_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      csum_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
`ifdef BOOT_TIMEOUT_EN
      if (busy && !accept && (to_cnt_q + 16'd1 == TO_LIMIT)) state_q <= S_ERR;
      else                                                     state_q <= state_d;
`else
      state_q     <= state_d;
`endif
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      csum_q      <= csum_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frame loads, checksum/length errors, noise, gaps, resets.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [11:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [43:0] exp_q[$];
  logic [43:0] got_q[$];

  always #5 clk = ~clk;

  imem_boot_loader #(
    .IMEM_DEPTH_WORDS(4096),
    .MAGIC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // Write monitor: every IMEM strobe seen mid-cycle becomes one {addr, data} record.
  always @(negedge clk) begin
    if (imem_we === 1'b1) got_q.push_back({imem_waddr, imem_wdata});
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
  endtask

  // Payload 13,00,50,00,93,00,A0,00 XORs to 0x70.
  task automatic send_payload(input int gap);
    logic [7:0] pl [8];
    pl = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      send_byte(pl[i]);
      if (i != 7) repeat (gap) @(posedge clk);
    end
  endtask

  task automatic load_two_words_exp();
    exp_q.delete();
    exp_q.push_back({12'd0, 32'h00500013});
    exp_q.push_back({12'd1, 32'h00A00093});
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({in_ready, imem_we, cpu_rst_n, busy, done, error} !== 6'b100000)
      $display("FAIL reset_flags got=%b exp=100000", {in_ready, imem_we, cpu_rst_n, busy, done, error});
    else pass_cnt++;
    chk_cnt++;
    if (imem_waddr !== 12'd0 || imem_wdata !== 32'd0)
      $display("FAIL reset_addr_data got=%h/%h exp=000/00000000", imem_waddr, imem_wdata);
    else pass_cnt++;
    rst_n = 1'b1;
    got_q.delete();
  endtask

  task automatic test_good_load();
    do_reset();
    load_two_words_exp();
    send_byte(8'hA5);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL good_busy_after_magic got=%b exp=1", busy);
    else pass_cnt++;
    send_byte(8'h02);
    send_byte(8'h00);
    send_payload(0);
    send_byte(8'h70);
    chk_cnt++;
    if ({done, in_ready, cpu_rst_n, busy} !== 4'b1000)
      $display("FAIL good_csum_edge got=%b exp=1000", {done, in_ready, cpu_rst_n, busy});
    else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (cpu_rst_n !== 1'b1) $display("FAIL good_cpu_release got=%b exp=1", cpu_rst_n);
    else pass_cnt++;
    // Bytes offered in RUN must be ignored.
    send_byte(8'hA5);
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({done, cpu_rst_n, error} !== 3'b110)
      $display("FAIL good_run_sticky got=%b exp=110", {done, cpu_rst_n, error});
    else pass_cnt++;
    chk_cnt++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL good_write_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL good_write%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 44'h0, exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    load_two_words_exp();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_payload(0);
    send_byte(8'h39);
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({error, cpu_rst_n, done, busy} !== 4'b1000)
      $display("FAIL bad_csum_err got=%b exp=1000", {error, cpu_rst_n, done, busy});
    else pass_cnt++;
    chk_cnt++;
    if (got_q.size() !== 2) $display("FAIL bad_csum_writes got=%0d exp=2", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL bad_csum_write%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 44'h0, exp_q[i]);
      else pass_cnt++;
    end
    // Empty frame recovers from ERR.
    send_byte(8'hA5);
    chk_cnt++;
    if ({error, busy} !== 2'b01) $display("FAIL err_recover_magic got=%b exp=01", {error, busy});
    else pass_cnt++;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({done, cpu_rst_n, error} !== 3'b110)
      $display("FAIL empty_frame_run got=%b exp=110", {done, cpu_rst_n, error});
    else pass_cnt++;
    chk_cnt++;
    if (got_q.size() !== 2) $display("FAIL empty_frame_writes got=%0d exp=2", got_q.size());
    else pass_cnt++;
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    chk_cnt++;
    if ({error, busy, cpu_rst_n} !== 3'b100)
      $display("FAIL oversize_err got=%b exp=100", {error, busy, cpu_rst_n});
    else pass_cnt++;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    @(posedge clk);
    #1;
    chk_cnt++;
    if (got_q.size() !== 0 || error !== 1'b1)
      $display("FAIL oversize_no_write got=%0d/%b exp=0/1", got_q.size(), error);
    else pass_cnt++;
    // Exactly IMEM_DEPTH_WORDS is legal.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h10);
    chk_cnt++;
    if ({error, busy} !== 2'b01) $display("FAIL len_max_legal got=%b exp=01", {error, busy});
    else pass_cnt++;
  endtask

  task automatic test_noise_gaps();
    do_reset();
    load_two_words_exp();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    chk_cnt++;
    if ({busy, error, done} !== 3'b000) $display("FAIL noise_idle got=%b exp=000", {busy, error, done});
    else pass_cnt++;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_payload(10);
    send_byte(8'h70);
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({done, cpu_rst_n, error} !== 3'b110)
      $display("FAIL gaps_run got=%b exp=110", {done, cpu_rst_n, error});
    else pass_cnt++;
    chk_cnt++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL gaps_write_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL gaps_write%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 44'h0, exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_cnt++;
    if ({in_ready, imem_we, cpu_rst_n, busy, done, error} !== 6'b100000 ||
        imem_waddr !== 12'd0 || imem_wdata !== 32'd0)
      $display("FAIL midreset_outputs got=%b/%h/%h exp=100000/000/00000000",
               {in_ready, imem_we, cpu_rst_n, busy, done, error}, imem_waddr, imem_wdata);
    else pass_cnt++;
    // Reset on the same edge as the 4th byte suppresses the write.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h44;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (got_q.size() !== 0 || busy !== 1'b0)
      $display("FAIL midreset_no_write got=%0d/%b exp=0/0", got_q.size(), busy);
    else pass_cnt++;
    load_two_words_exp();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_payload(0);
    send_byte(8'h70);
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({done, cpu_rst_n} !== 2'b11) $display("FAIL midreset_reload_run got=%b exp=11", {done, cpu_rst_n});
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q.size() !== exp_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL midreset_write%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 44'h0, exp_q[i]);
      else pass_cnt++;
    end
  endtask

`ifdef BOOT_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h13);
    repeat (25) @(posedge clk);
    #1;
    chk_cnt++;
    if ({error, cpu_rst_n, busy} !== 3'b100)
      $display("FAIL timeout_err got=%b exp=100", {error, cpu_rst_n, busy});
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_good_load();
    test_bad_csum();
    test_oversize();
    test_noise_gaps();
    test_reset_mid_frame();
`ifdef BOOT_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
